ifmap_buffer_ctrl: RTL and testbench

Multi-bank input-feature-map buffer controller that sits directly downstream of the NOC completion logic.
- The DRAM loader streams ifmap words into rotating banks.
- The PE array reads from the oldest full bank.
- A bank is released when the NOC pulses free_ifmap_buffer, so the loader can refill it while the PE array consumes the next bank.

---
 rtl/ifmap_buffer_ctrl.sv | 114 +++++++++++
 tb/tb_ifmap_buffer_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_buffer_ctrl.sv
// Multi-bank ifmap buffer: the loader fills banks in rotation, the PE array reads
// the oldest FULL bank, and a NOC free pulse returns that bank to the loader.
module ifmap_buffer_ctrl #(
  parameter int DATA_W     = 64,
  parameter int BANK_DEPTH = 64,
  parameter int NUM_BANKS  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic                                 wr_last,
  input  logic                                 rd_req,
  input  logic [$clog2(BANK_DEPTH)-1:0]        rd_addr,
  output logic                                 rd_valid,
  output logic [DATA_W-1:0]                    rd_data,
  output logic                                 batch_ready,
  output logic [$clog2(BANK_DEPTH):0]          batch_len,
  input  logic                                 free_ifmap_buffer,
  output logic [$clog2(NUM_BANKS):0]           full_banks,
  output logic                                 free_err
);

  localparam int AW = $clog2(BANK_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = BW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } bank_state_e;

  bank_state_e       bank_st  [NUM_BANKS];
  logic [LW-1:0]     bank_len [NUM_BANKS];
  logic [DATA_W-1:0] mem      [NUM_BANKS][BANK_DEPTH];

  logic [BW-1:0] wr_bank;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] full_cnt;

  logic wr_accept;
  logic wr_close;
  logic free_ok;
  logic rd_fire;

  assign wr_ready    = (bank_st[wr_bank] != ST_FULL);
  assign batch_ready = (bank_st[rd_bank] == ST_FULL);
  assign batch_len   = batch_ready ? bank_len[rd_bank] : '0;
  assign full_banks  = full_cnt;

  assign wr_accept = wr_valid & wr_ready;
  assign wr_close  = wr_accept & (wr_last | (wr_addr == AW'(BANK_DEPTH - 1)));
  assign free_ok   = free_ifmap_buffer & batch_ready;
  assign rd_fire   = rd_req & batch_ready;

  // Writes only hit non-FULL banks and reads only the FULL one, so no port conflict.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        bank_st[BW'(b)]  <= ST_EMPTY;
        bank_len[BW'(b)] <= '0;
      end
      wr_bank  <= '0;
      rd_bank  <= '0;
      wr_addr  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      free_err <= 1'b0;
      full_cnt <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_data <= mem[rd_bank][rd_addr];
      end

      if (wr_accept) begin
        if (wr_close) begin
          bank_st[wr_bank]  <= ST_FULL;
          bank_len[wr_bank] <= LW'(wr_addr) + LW'(1);
          wr_bank           <= wr_bank + 1'b1;
          wr_addr           <= '0;
        end else begin
          bank_st[wr_bank] <= ST_FILLING;
          wr_addr          <= wr_addr + 1'b1;
        end
      end

      // The freed bank is FULL, the written bank is not, so both updates can land together.
      if (free_ifmap_buffer) begin
        if (batch_ready) begin
          bank_st[rd_bank]  <= ST_EMPTY;
          bank_len[rd_bank] <= '0;
          rd_bank           <= rd_bank + 1'b1;
        end else begin
          free_err <= 1'b1;
        end
      end

      full_cnt <= full_cnt + CW'(wr_close) - CW'(free_ok);
    end
  end

endmodule

// File: tb/tb_ifmap_buffer_ctrl.sv
// Bench for ifmap_buffer_ctrl: directed scenarios with literal expectations, then
// random traffic compared each cycle against a batch-queue model.
module tb_ifmap_buffer_ctrl;

  localparam int DW = 64;
  localparam int D  = 64;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          rd_req;
  logic [5:0]    rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          batch_ready;
  logic [6:0]    batch_len;
  logic          free_ifmap_buffer;
  logic [1:0]    full_banks;
  logic          free_err;

  ifmap_buffer_ctrl #(
    .DATA_W(DW),
    .BANK_DEPTH(D),
    .NUM_BANKS(NB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .batch_ready(batch_ready),
    .batch_len(batch_len),
    .free_ifmap_buffer(free_ifmap_buffer),
    .full_banks(full_banks),
    .free_err(free_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: completed batches form a FIFO; the oldest is the one the PE array sees.
  typedef struct {
    int bank;
    int len;
  } batch_t;

  batch_t        q[$];
  logic [DW-1:0] mm[NB][D];
  int            m_wbank = 0;
  int            m_waddr = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_ferr  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n || start) begin
      q.delete();
      m_wbank = 0;
      m_waddr = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ferr  = 1'b0;
    end else begin
      bit ready;
      bit space;
      ready = (q.size() != 0);
      space = (q.size() < NB);
      m_valid = rd_req && ready;
      if (rd_req && ready) m_data = mm[q[0].bank][rd_addr];
      if (free_ifmap_buffer) begin
        if (ready) void'(q.pop_front());
        else m_ferr = 1'b1;
      end
      if (wr_valid && space) begin
        mm[m_wbank][m_waddr] = wr_data;
        if (wr_last || m_waddr == D - 1) begin
          q.push_back('{bank: m_wbank, len: m_waddr + 1});
          m_wbank = (m_wbank + 1) % NB;
          m_waddr = 0;
        end else begin
          m_waddr++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_ready", 64'(wr_ready), 64'(q.size() < NB));
      chk("batch_ready", 64'(batch_ready), 64'(q.size() != 0));
      chk("batch_len", 64'(batch_len), (q.size() != 0) ? 64'(q[0].len) : 64'd0);
      chk("full_banks", 64'(full_banks), 64'(q.size()));
      chk("rd_valid", 64'(rd_valid), 64'(m_valid));
      chk("rd_data", rd_data, m_data);
      chk("free_err", 64'(free_err), 64'(m_ferr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 0; wr_valid = 0; wr_data = '0; wr_last = 0;
    rd_req = 0; rd_addr = '0; free_ifmap_buffer = 0;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic last);
    wr_valid = 1; wr_data = d; wr_last = last;
    tick();
    wr_valid = 0; wr_last = 0;
  endtask

  task automatic read(input logic [5:0] a);
    rd_req = 1; rd_addr = a;
    tick();
    rd_req = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic pulse_free();
    free_ifmap_buffer = 1;
    tick();
    free_ifmap_buffer = 0;
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst full_banks", 64'(full_banks), 64'd0);
    chk("rst wr_ready", 64'(wr_ready), 64'd1);
    chk("rst rd_data", rd_data, 64'd0);
    rst_n = 1;

    // 1: one full batch of 64, then a single read
    for (int i = 0; i < 64; i++) put(DW'(i), i == 63);
    chk("t1 batch_len", 64'(batch_len), 64'd64);
    chk("t1 full_banks", 64'(full_banks), 64'd1);
    chk("t1 batch_ready", 64'(batch_ready), 64'd1);
    read(6'd5);
    chk("t1 rd_valid", 64'(rd_valid), 64'd1);
    chk("t1 rd_data", rd_data, 64'd5);

    // 2: both banks full, free exposes the short batch
    do_start();
    for (int i = 0; i < 64; i++) put(DW'(i), 1'b0);
    for (int i = 0; i < 20; i++) put(DW'(100 + i), i == 19);
    chk("t2 full_banks", 64'(full_banks), 64'd2);
    chk("t2 wr_ready", 64'(wr_ready), 64'd0);
    free_ifmap_buffer = 1;
    #1;
    chk("t2 wr_ready comb", 64'(wr_ready), 64'd0);
    tick();
    free_ifmap_buffer = 0;
    chk("t2 batch_len", 64'(batch_len), 64'd20);
    chk("t2 wr_ready after", 64'(wr_ready), 64'd1);

    // 3: free with nothing full
    rst_n = 0;
    tick();
    rst_n = 1;
    pulse_free();
    chk("t3 free_err", 64'(free_err), 64'd1);
    chk("t3 full_banks", 64'(full_banks), 64'd0);
    do_start();
    chk("t3 free_err clr", 64'(free_err), 64'd0);

    // 4: read + free + write-complete in one cycle
    for (int i = 0; i < 64; i++) put(DW'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 19; i++) put(DW'(200 + i), 1'b0);
    wr_valid = 1; wr_data = DW'(219); wr_last = 1;
    rd_req = 1; rd_addr = 6'd3; free_ifmap_buffer = 1;
    tick();
    clear_in();
    chk("t4 rd_data", rd_data, 64'hA3);
    chk("t4 full_banks", 64'(full_banks), 64'd1);
    chk("t4 batch_ready", 64'(batch_ready), 64'd1);
    chk("t4 batch_len", 64'(batch_len), 64'd20);

    // 5: ignored read, then a one-word batch
    pulse_free();
    read(6'd0);
    chk("t5 rd_valid", 64'(rd_valid), 64'd0);
    chk("t5 rd_data hold", rd_data, 64'hA3);
    put(DW'(7), 1'b1);
    chk("t5 batch_len", 64'(batch_len), 64'd1);
    read(6'd0);
    chk("t5 rd_data", rd_data, 64'd7);

    // 6: reset in the middle of a fill
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 30; i++) put(DW'(i), 1'b0);
    rst_n = 0; wr_valid = 1; wr_data = DW'(30);
    tick();
    rst_n = 1; wr_valid = 0;
    chk("t6 full_banks", 64'(full_banks), 64'd0);
    chk("t6 wr_ready", 64'(wr_ready), 64'd1);
    chk("t6 rd_valid", 64'(rd_valid), 64'd0);
    put(DW'(9), 1'b1);
    chk("t6 batch_len", 64'(batch_len), 64'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n             = ($urandom_range(199, 0) != 0);
      start             = ($urandom_range(149, 0) == 0);
      wr_valid          = ($urandom_range(9, 0) < 6);
      wr_data           = {$urandom, $urandom};
      wr_last           = ($urandom_range(15, 0) == 0);
      rd_req            = $urandom_range(1, 0) != 0;
      free_ifmap_buffer = ($urandom_range(29, 0) == 0);
      if (q.size() != 0) rd_addr = 6'($urandom_range(q[0].len - 1, 0));
      else rd_addr = 6'($urandom_range(63, 0));
      tick();
    end
    clear_in();
    rst_n = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
